threshold_monitor_4bit: RTL and testbench

Sequential consumer of the 4-bit magnitude comparator. Receives a stream of 4-bit samples with a valid strobe and compares each sample against a high and a low threshold. A debounce/hysteresis FSM raises a sticky alarm after DEBOUNCE consecutive samples above the high threshold, and clears it after DEBOUNCE consecutive samples below the low threshold. It also counts alarm events. It sits directly downstream of the comparator and consumes its gt/lt/eq flags.

---
 rtl/threshold_monitor_pkg.sv | 20 ++
 rtl/comparator_4bit_struct.sv | 14 +
 rtl/threshold_monitor_4bit.sv | 171 +++++++++++++++++
 tb/tb_threshold_monitor_4bit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/threshold_monitor_pkg.sv
// Shared types and constants for the threshold monitor and the comparators it uses.
package threshold_monitor_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEB_CNT_W = 4;

  typedef enum logic [1:0] {
    NORMAL    = 2'b00,
    PEND_HIGH = 2'b01,
    ALARM     = 2'b10,
    PEND_LOW  = 2'b11
  } mon_state_t;

  typedef struct packed {
    logic a_maior_que_b;
    logic a_menor_que_b;
    logic a_igual_b;
  } cmp_flags_t;

endpackage

// File: rtl/comparator_4bit_struct.sv
// Unsigned 4-bit magnitude comparator; exactly one flag is high for any a/b pair.
module comparator_4bit_struct
  import threshold_monitor_pkg::*;
(
  input  logic [DEF_WIDTH-1:0] a,
  input  logic [DEF_WIDTH-1:0] b,
  output cmp_flags_t           flags
);

  assign flags.a_maior_que_b = (a > b);
  assign flags.a_menor_que_b = (a < b);
  assign flags.a_igual_b     = (a == b);

endmodule

// File: rtl/threshold_monitor_4bit.sv
// Debounced high/low threshold alarm with a saturating alarm-entry counter.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// NORMAL    | no alarm, no qualifying run in progress
// PEND_HIGH | no alarm yet, cnt samples in a row above thr_high so far
// ALARM     | alarm raised, no exit run in progress
// PEND_LOW  | alarm still raised, cnt samples in a row below thr_low so far
module threshold_monitor_4bit
  import threshold_monitor_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] thr_high,
  input  logic [WIDTH-1:0] thr_low,
  output logic             alarm,
  output logic             alarm_rise,
  output logic [CNT_W-1:0] event_count,
  output logic             cfg_err,
  output logic             gt_q,
  output logic             lt_q,
  output logic             eq_q
);

  localparam logic [DEB_CNT_W:0] DEB_L   = (DEB_CNT_W+1)'(DEBOUNCE);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  cmp_flags_t cmp_high;
  cmp_flags_t cmp_low;

  mon_state_t           state_q, state_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic [DEB_CNT_W:0]   cnt_inc;
  logic                 rise_d;
  logic                 above, below;
  logic                 cfg_err_q, alarm_rise_q;
  logic                 gt_r, lt_r, eq_r;
  logic [CNT_W-1:0]     event_count_q;

  comparator_4bit_struct u_cmp_high (
    .a     (sample),
    .b     (thr_high),
    .flags (cmp_high)
  );

  comparator_4bit_struct u_cmp_low (
    .a     (sample),
    .b     (thr_low),
    .flags (cmp_low)
  );

  // Equality never qualifies; the low side folds in all three flags so a
  // malformed flag set from the comparator cannot count as "below".
  assign above   = cmp_high.a_maior_que_b;
  assign below   = cmp_low.a_menor_que_b & ~cmp_low.a_igual_b & ~cmp_low.a_maior_que_b;
  assign cnt_inc = {1'b0, cnt_q} + {{DEB_CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    if (sample_valid && !cfg_err_q) begin
      unique case (state_q)
        NORMAL: begin
          if (above) begin
            if (DEBOUNCE == 1) begin
              state_d = ALARM;
              cnt_d   = '0;
              rise_d  = 1'b1;
            end else begin
              state_d = PEND_HIGH;
              cnt_d   = {{(DEB_CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        PEND_HIGH: begin
          if (!above) begin
            state_d = NORMAL;
            cnt_d   = '0;
          end else if (cnt_inc == DEB_L) begin
            state_d = ALARM;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc[DEB_CNT_W-1:0];
          end
        end
        ALARM: begin
          if (below) begin
            if (DEBOUNCE == 1) begin
              state_d = NORMAL;
              cnt_d   = '0;
            end else begin
              state_d = PEND_LOW;
              cnt_d   = {{(DEB_CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        PEND_LOW: begin
          if (!below) begin
            state_d = ALARM;
            cnt_d   = '0;
          end else if (cnt_inc == DEB_L) begin
            state_d = NORMAL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[DEB_CNT_W-1:0];
          end
        end
        default: begin
          state_d = NORMAL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= NORMAL;
      cnt_q         <= '0;
      alarm_rise_q  <= 1'b0;
      event_count_q <= '0;
      cfg_err_q     <= 1'b0;
      gt_r          <= 1'b0;
      lt_r          <= 1'b0;
      eq_r          <= 1'b0;
    end else begin
      // cfg_err keeps tracking the thresholds even through a clear
      cfg_err_q <= (thr_low > thr_high);
      if (clear) begin
        state_q       <= NORMAL;
        cnt_q         <= '0;
        alarm_rise_q  <= 1'b0;
        event_count_q <= '0;
        gt_r          <= 1'b0;
        lt_r          <= 1'b0;
        eq_r          <= 1'b0;
      end else begin
        state_q      <= state_d;
        cnt_q        <= cnt_d;
        alarm_rise_q <= rise_d;
        if (rise_d && (event_count_q != CNT_MAX))
          event_count_q <= event_count_q + CNT_ONE;
        if (sample_valid) begin
          gt_r <= cmp_high.a_maior_que_b;
          lt_r <= cmp_high.a_menor_que_b;
          eq_r <= cmp_high.a_igual_b;
        end
      end
    end
  end

  // ALARM and PEND_LOW share the state MSB, so alarm comes straight off the register
  assign alarm       = state_q[1];
  assign alarm_rise  = alarm_rise_q;
  assign event_count = event_count_q;
  assign cfg_err     = cfg_err_q;
  assign gt_q        = gt_r;
  assign lt_q        = lt_r;
  assign eq_q        = eq_r;

endmodule

// File: tb/tb_threshold_monitor_4bit.sv
// Scoreboard bench: stimulus queues the expected post-edge outputs, a monitor checks them.
module tb_threshold_monitor_4bit;

  typedef struct packed {
    logic       alarm;
    logic       rise;
    logic [7:0] cnt;
    logic       cfg;
    logic       gt;
    logic       lt;
    logic       eq;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       sample_valid;
  logic [3:0] sample;
  logic [3:0] thr_high;
  logic [3:0] thr_low;
  logic       alarm, alarm_rise, cfg_err, gt_q, lt_q, eq_q;
  logic [7:0] event_count;

  obs_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  logic [7:0] ev_m;
  logic       cfg_m, gt_m, lt_m, eq_m;

  threshold_monitor_4bit #(.WIDTH(4), .DEBOUNCE(3), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .sample_valid (sample_valid),
    .sample       (sample),
    .thr_high     (thr_high),
    .thr_low      (thr_low),
    .alarm        (alarm),
    .alarm_rise   (alarm_rise),
    .event_count  (event_count),
    .cfg_err      (cfg_err),
    .gt_q         (gt_q),
    .lt_q         (lt_q),
    .eq_q         (eq_q)
  );

  always #5 clk = ~clk;

  // monitor: outputs only move on posedge, so negedge is a stable sample point
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {alarm, alarm_rise, event_count, cfg_err, gt_q, lt_q, eq_q};
        chk_cnt++;
        if (a === e) pass_cnt++;
        else
          $display("FAIL obs#%0d @%0t: got alarm=%0b rise=%0b ev=%0d cfg=%0b gt/lt/eq=%0b%0b%0b, want alarm=%0b rise=%0b ev=%0d cfg=%0b gt/lt/eq=%0b%0b%0b",
                   chk_cnt, $time, a.alarm, a.rise, a.cnt, a.cfg, a.gt, a.lt, a.eq,
                   e.alarm, e.rise, e.cnt, e.cfg, e.gt, e.lt, e.eq);
      end
    end
  end

  task automatic cyc(input logic v, input logic [3:0] s, input logic a, input logic r,
                     input logic clr);
    logic cfg_next;
    sample_valid = v;
    sample       = s;
    clear        = clr;
    cfg_next     = (thr_low > thr_high);
    @(posedge clk);
    #1;
    cfg_m = cfg_next;
    if (clr) begin
      ev_m = 8'd0;
      gt_m = 1'b0;
      lt_m = 1'b0;
      eq_m = 1'b0;
    end else begin
      if (r && ev_m != 8'd255) ev_m = ev_m + 8'd1;
      if (v) begin
        gt_m = (s > thr_high);
        lt_m = (s < thr_high);
        eq_m = (s == thr_high);
      end
    end
    exp_q.push_back({a, r, ev_m, cfg_m, gt_m, lt_m, eq_m});
    clear = 1'b0;
  endtask

  task automatic smp(input logic [3:0] s, input logic a, input logic r);
    cyc(1'b1, s, a, r, 1'b0);
  endtask

  task automatic idle(input logic a);
    cyc(1'b0, 4'd0, a, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", chk_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; sample_valid = 1'b0; sample = 4'd0;
    thr_high = 4'd10; thr_low = 4'd4;
    ev_m = 8'd0; cfg_m = 1'b0; gt_m = 1'b0; lt_m = 1'b0; eq_m = 1'b0;

    // reset state while rst_n is held low
    @(posedge clk); #1;
    exp_q.push_back('0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle(1'b0);

    // entry after three samples above 10
    smp(4'd11, 1'b0, 1'b0); smp(4'd12, 1'b0, 1'b0); smp(4'd13, 1'b1, 1'b1);
    idle(1'b1);

    // exit: 5 breaks the first low run, then 3,2,1 completes
    smp(4'd3, 1'b1, 1'b0); smp(4'd2, 1'b1, 1'b0); smp(4'd5, 1'b1, 1'b0);
    smp(4'd3, 1'b1, 1'b0); smp(4'd2, 1'b1, 1'b0); smp(4'd1, 1'b0, 1'b0);
    idle(1'b0);

    // equality with thr_high breaks the run
    smp(4'd11, 1'b0, 1'b0); smp(4'd12, 1'b0, 1'b0); smp(4'd10, 1'b0, 1'b0);
    smp(4'd11, 1'b0, 1'b0); smp(4'd0, 1'b0, 1'b0);

    // idle cycles hold the partial count
    smp(4'd11, 1'b0, 1'b0);
    repeat (5) idle(1'b0);
    smp(4'd12, 1'b0, 1'b0); smp(4'd13, 1'b1, 1'b1);

    // equality with thr_low breaks the exit run
    smp(4'd3, 1'b1, 1'b0); smp(4'd4, 1'b1, 1'b0); smp(4'd3, 1'b1, 1'b0);
    smp(4'd2, 1'b1, 1'b0); smp(4'd1, 1'b0, 1'b0);

    // inverted thresholds: samples ignored, flags still track
    thr_low = 4'd12;
    idle(1'b0);
    repeat (4) smp(4'd15, 1'b0, 1'b0);
    thr_low = 4'd4;
    idle(1'b0);
    smp(4'd15, 1'b0, 1'b0); smp(4'd15, 1'b0, 1'b0); smp(4'd15, 1'b1, 1'b1);
    smp(4'd0, 1'b1, 1'b0); smp(4'd0, 1'b1, 1'b0); smp(4'd0, 1'b0, 1'b0);

    // event counter saturation
    for (int i = 0; i < 256; i++) begin
      smp(4'd11, 1'b0, 1'b0); smp(4'd11, 1'b0, 1'b0); smp(4'd11, 1'b1, 1'b1);
      smp(4'd0, 1'b1, 1'b0);  smp(4'd0, 1'b1, 1'b0);  smp(4'd0, 1'b0, 1'b0);
    end
    idle(1'b0);

    // clear beats a qualifying third sample
    smp(4'd11, 1'b0, 1'b0); smp(4'd12, 1'b0, 1'b0);
    cyc(1'b1, 4'd13, 1'b0, 1'b0, 1'b1);
    smp(4'd11, 1'b0, 1'b0); smp(4'd12, 1'b0, 1'b0);

    // async reset mid-PEND_HIGH discards the partial run
    @(negedge clk); #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    ev_m = 8'd0; cfg_m = 1'b0; gt_m = 1'b0; lt_m = 1'b0; eq_m = 1'b0;
    idle(1'b0);
    smp(4'd13, 1'b0, 1'b0); smp(4'd14, 1'b0, 1'b0); smp(4'd15, 1'b1, 1'b1);

    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
